// File: rtl/ra_pkg.sv
// Shared constants and helpers for the return-address stack.
package ra_pkg;

    localparam int RA_W     = 32;
    localparam int RA_DEPTH = 8;

    // Bits needed to hold an occupancy value in 0..depth inclusive.
    function automatic int ra_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ra_stack_ptr.sv
// Stack pointer and occupancy tracking for ra_stack.
// Produces the entry write strobe/index, the read index of the top entry,
// and the status flags (empty, full, sticky overflow, underflow pulse).
module ra_stack_ptr
    import ra_pkg::*;
#(
    parameter int DEPTH = RA_DEPTH,
    parameter int SPW   = $clog2(DEPTH),
    parameter int CW    = ra_cnt_w(DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    input  logic           push,
    input  logic           pop,
    output logic           wr_en,
    output logic [SPW-1:0] wr_idx,
    output logic [SPW-1:0] rd_idx,
    output logic [CW-1:0]  count,
    output logic           empty,
    output logic           full,
    output logic           overflow,
    output logic           underflow
);

    localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEPTH);

    logic [SPW-1:0] sp_q, sp_d;
    logic [CW-1:0]  count_d;
    logic           ovf_d, unf_d;

    assign empty  = (count == '0);
    assign full   = (count == CNT_MAX);
    assign rd_idx = sp_q - SP_ONE;

    // Next pointer/count/flag values and entry write selection.
    always_comb begin
        sp_d    = sp_q;
        count_d = count;
        ovf_d   = overflow;
        unf_d   = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = sp_q;
        if (flush) begin
            sp_d    = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (push && pop && !empty) begin
            // Return-then-call: replace the top entry in place.
            wr_en  = 1'b1;
            wr_idx = sp_q - SP_ONE;
        end else if (push) begin
            // Push wraps over the oldest entry when full; count saturates.
            wr_en = 1'b1;
            sp_d  = sp_q + SP_ONE;
            if (full) ovf_d = 1'b1;
            else      count_d = count + CNT_ONE;
        end else if (pop) begin
            if (empty) begin
                unf_d = 1'b1;
            end else begin
                sp_d    = sp_q - SP_ONE;
                count_d = count - CNT_ONE;
            end
        end
    end

    // Pointer, occupancy and flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp_q      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            sp_q      <= sp_d;
            count     <= count_d;
            overflow  <= ovf_d;
            underflow <= unf_d;
        end
    end

endmodule

// File: rtl/ra_stack.sv
// Return-address stack: circular entry storage plus top-of-stack mux.
// Define RA_STACK_BYPASS_EN to forward an incoming push straight to top in
// the same cycle; by default top comes only from registered state.
module ra_stack
    import ra_pkg::*;
#(
    parameter int N     = RA_W,
    parameter int DEPTH = RA_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [N-1:0]               push_data,
    output logic [N-1:0]               top,
    output logic [ra_cnt_w(DEPTH)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int SPW = $clog2(DEPTH);
    localparam int CW  = ra_cnt_w(DEPTH);

    if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ra_stack: DEPTH must be a power of two in 2..64");
    end

    logic [N-1:0]   mem [DEPTH];
    logic           push_eff;
    logic           wr_en;
    logic [SPW-1:0] wr_idx, rd_idx;
    logic [N-1:0]   top_reg;

    // A zero return address is treated as "no call".
    assign push_eff = push && (push_data != '0);

    ra_stack_ptr #(
        .DEPTH (DEPTH),
        .SPW   (SPW),
        .CW    (CW)
    ) u_ptr (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (push_eff),
        .pop       (pop),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .rd_idx    (rd_idx),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    // Entry storage; contents survive pop and flush, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_idx] <= push_data;
        end
    end

    assign top_reg = empty ? '0 : mem[rd_idx];

`ifdef RA_STACK_BYPASS_EN
    // Forward the incoming return address ahead of the storage write.
    always_comb begin
        top = top_reg;
        if (push_eff && !flush) top = push_data;
    end
`else
    // Registered-only top of stack.
    always_comb begin
        top = top_reg;
    end
`endif

endmodule
